exe_stage_pipe: RTL and testbench



---
 rtl/exe_stage_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_exe_stage_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_pipe.sv
// Registered ARM-subset execute stage: Val2, ALU, branch target and EXE/MEM output register.
// Define EXE_MUL_EN to include the iterative MUL/MLA multiplier; otherwise MUL/MLA return 0 in one cycle.
module exe_stage_pipe #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MUL_BITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [DATA_W-1:0] PC,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic              WB_EN,
   input  logic              B,
   input  logic              S,
   input  logic              I,
   input  logic [3:0]        EXE_CMD,
   input  logic [3:0]        Dest,
   input  logic [DATA_W-1:0] Val_RN,
   input  logic [DATA_W-1:0] Val_RM,
   input  logic [DATA_W-1:0] Val_RS,
   input  logic [11:0]       imm,
   input  logic [11:0]       shift_operand,
   input  logic [23:0]       signed_immed_24,
   input  logic [3:0]        status,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ALU_result,
   output logic [DATA_W-1:0] Val_RM_out,
   output logic [DATA_W-1:0] BranchAddr,
   output logic [3:0]        Dest_out,
   output logic              WB_EN_out,
   output logic              MEM_R_EN_out,
   output logic              MEM_W_EN_out,
   output logic              B_out,
   output logic [3:0]        status_out,
   output logic              status_we
);
   localparam int unsigned MSB   = DATA_W - 1;
   localparam int unsigned SUM_W = DATA_W + 1;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1010;
   localparam logic [3:0] CMD_MLA = 4'b1011;

   logic [2*DATA_W-1:0] w_imm_dbl, w_rm_dbl;
   logic [DATA_W-1:0]   w_shifted, w_val2, w_b, w_res, w_br, w_sext;
   logic [DATA_W:0]     w_sum;
   logic                w_cin, w_arith, w_c, w_v;
   logic [3:0]          w_flags;
   logic                w_idle, w_xfer, w_load_single, w_mul_done;

   logic              r_valid, r_wb, r_mr, r_mw, r_b, r_s;
   logic [DATA_W-1:0] r_alu, r_rm_out, r_br;
   logic [3:0]        r_dest, r_status;

   // Operand 2: rotated immediate, memory offset or shifted Rm.
   always_comb begin
      w_imm_dbl = {2{DATA_W'(imm[7:0])}} >> {imm[11:8], 1'b0};
      w_rm_dbl  = {Val_RM, Val_RM} >> shift_operand[11:7];
      case (shift_operand[6:5])
         2'b00:   w_shifted = Val_RM << shift_operand[11:7];
         2'b01:   w_shifted = Val_RM >> shift_operand[11:7];
         2'b10:   w_shifted = $unsigned($signed(Val_RM) >>> shift_operand[11:7]);
         default: w_shifted = w_rm_dbl[DATA_W-1:0];
      endcase
      if (I)                        w_val2 = w_imm_dbl[DATA_W-1:0];
      else if (MEM_R_EN | MEM_W_EN) w_val2 = DATA_W'(imm);
      else                          w_val2 = w_shifted;
   end

   // ALU; subtraction is Rn + ~Val2 + cin so carry is the ARM not-borrow.
   always_comb begin
      w_b     = w_val2;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      case (EXE_CMD)
         CMD_ADD: w_arith = 1'b1;
         CMD_ADC: begin w_arith = 1'b1; w_cin = status[1]; end
         CMD_SUB: begin w_arith = 1'b1; w_b = ~w_val2; w_cin = 1'b1; end
         CMD_SBC: begin w_arith = 1'b1; w_b = ~w_val2; w_cin = status[1]; end
         default: ;
      endcase
      w_sum = {1'b0, Val_RN} + {1'b0, w_b} + SUM_W'(w_cin);
      case (EXE_CMD)
         CMD_MOV: w_res = w_val2;
         CMD_MVN: w_res = ~w_val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: w_res = w_sum[DATA_W-1:0];
         CMD_AND: w_res = Val_RN & w_val2;
         CMD_ORR: w_res = Val_RN | w_val2;
         CMD_EOR: w_res = Val_RN ^ w_val2;
         default: w_res = '0;
      endcase
      w_c = w_arith ? w_sum[DATA_W] : status[1];
      w_v = w_arith ? ((Val_RN[MSB] == w_b[MSB]) && (w_sum[MSB] != Val_RN[MSB])) : status[0];
      w_flags = {w_res[MSB], w_res == '0, w_c, w_v};
`ifndef EXE_MUL_EN
      if (EXE_CMD == CMD_MUL || EXE_CMD == CMD_MLA) w_flags = status;
`endif
   end

   assign w_sext = {{(DATA_W-24){signed_immed_24[23]}}, signed_immed_24};
   assign w_br   = PC + (w_sext << 2);

   assign in_ready = ~rst & w_idle & (~r_valid | out_ready) & ~flush;
   assign w_xfer   = in_valid & in_ready;

`ifdef EXE_MUL_EN
   localparam int unsigned STEPS = DATA_W / MUL_BITS;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [DATA_W-1:0]   r_mrm, r_mrs, r_mrn, r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_mla;
   logic [1:0]          r_cv;
   logic [MUL_BITS-1:0] w_digit;
   logic [DATA_W-1:0]   w_term, w_acc_next, w_mul_res;
   logic                w_is_mul, w_mul_start;

   assign w_is_mul      = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_MLA);
   assign w_mul_start   = w_xfer & w_is_mul;
   assign w_load_single = w_xfer & ~w_is_mul;
   assign w_idle        = (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mul_done  = 1'b0;
      case (r_state)
         ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
         ST_MUL: begin
            if (flush) w_state_nxt = ST_IDLE;
            else if (r_cnt == LAST) begin
               w_state_nxt = ST_IDLE;
               w_mul_done  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // One Rs digit per cycle, weighted by its position.
   always_comb begin
      w_digit    = MUL_BITS'(r_mrs >> (32'(r_cnt) * MUL_BITS));
      w_term     = (r_mrm * DATA_W'(w_digit)) << (32'(r_cnt) * MUL_BITS);
      w_acc_next = r_acc + w_term;
      w_mul_res  = w_acc_next + (r_mla ? r_mrn : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mrm <= '0; r_mrs <= '0; r_mrn <= '0; r_acc <= '0;
         r_cnt <= '0; r_mla <= 1'b0; r_cv <= 2'b00;
      end else if (flush) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_mul_start) begin
         r_mrm <= Val_RM;
         r_mrs <= Val_RS;
         r_mrn <= Val_RN;
         r_mla <= (EXE_CMD == CMD_MLA);
         r_cv  <= status[1:0];
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == ST_MUL) begin
         r_acc <= w_acc_next;
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end
`else
   logic w_unused_rs;
   assign w_unused_rs   = ^Val_RS;
   assign w_idle        = 1'b1;
   assign w_mul_done    = 1'b0;
   assign w_load_single = w_xfer;
`endif

   logic w_unused_shop;
   assign w_unused_shop = ^shift_operand[4:0];

   // EXE/MEM output register; sideband fields are captured at transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0; r_alu <= '0; r_rm_out <= '0; r_br <= '0; r_dest <= '0;
         r_wb <= 1'b0; r_mr <= 1'b0; r_mw <= 1'b0; r_b <= 1'b0; r_s <= 1'b0;
         r_status <= '0;
      end else begin
         if (flush)                              r_valid <= 1'b0;
         else if (w_load_single || w_mul_done)   r_valid <= 1'b1;
         else if (out_ready)                     r_valid <= 1'b0;
         if (w_xfer) begin
            r_rm_out <= Val_RM;
            r_br     <= w_br;
            r_dest   <= Dest;
            r_wb     <= WB_EN;
            r_mr     <= MEM_R_EN;
            r_mw     <= MEM_W_EN;
            r_b      <= B;
            r_s      <= S;
         end
         if (w_load_single) begin
            r_alu    <= w_res;
            r_status <= w_flags;
         end
`ifdef EXE_MUL_EN
         if (w_mul_done) begin
            r_alu    <= w_mul_res;
            r_status <= {w_mul_res[MSB], w_mul_res == '0, r_cv};
         end
`endif
      end
   end

   assign out_valid    = r_valid;
   assign ALU_result   = r_alu;
   assign Val_RM_out   = r_rm_out;
   assign BranchAddr   = r_br;
   assign Dest_out     = r_dest;
   assign WB_EN_out    = r_wb;
   assign MEM_R_EN_out = r_mr;
   assign MEM_W_EN_out = r_mw;
   assign B_out        = r_b;
   assign status_out   = r_status;
   assign status_we    = r_s & r_valid;
endmodule

// File: tb/tb_exe_stage_pipe.sv
// Bench for exe_stage_pipe: arithmetic-level reference model plus hand-computed directed vectors.
module tb_exe_stage_pipe;
`ifdef EXE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam int STEPS       = 8;
   localparam int EXP_MUL_LAT = MUL_EN ? STEPS + 1 : 1;
   localparam int EXP_MUL_WAIT = MUL_EN ? STEPS : 0;
   localparam logic [31:0] EXP_MLA = MUL_EN ? 32'h0001_2341 : 32'h0;

   localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011,
                          SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111,
                          EOR = 4'b1000, MUL = 4'b1010, MLA = 4'b1011;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] PC, Val_RN, Val_RM, Val_RS, ALU_result, Val_RM_out, BranchAddr;
   logic MEM_R_EN, MEM_W_EN, WB_EN, B, S, I;
   logic WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, status_we;
   logic [3:0] EXE_CMD, Dest, status, Dest_out, status_out;
   logic [11:0] imm, shift_operand;
   logic [23:0] signed_immed_24;

   exe_stage_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .PC(PC), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .B(B), .S(S), .I(I),
      .EXE_CMD(EXE_CMD), .Dest(Dest), .Val_RN(Val_RN), .Val_RM(Val_RM), .Val_RS(Val_RS),
      .imm(imm), .shift_operand(shift_operand), .signed_immed_24(signed_immed_24),
      .status(status), .out_valid(out_valid), .out_ready(out_ready),
      .ALU_result(ALU_result), .Val_RM_out(Val_RM_out), .BranchAddr(BranchAddr),
      .Dest_out(Dest_out), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
      .MEM_W_EN_out(MEM_W_EN_out), .B_out(B_out), .status_out(status_out), .status_we(status_we)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0] cmd, dest, st;
      logic [31:0] rn, rm, rs, pc;
      logic [11:0] imm, shop;
      logic [23:0] simm;
      logic i, s, mr, mw, wb, b;
   } ins_t;

   typedef struct {
      logic [31:0] alu, rm, br;
      logic [3:0] dest, st;
      logic wb, mr, mw, b, s;
   } exp_t;

   function automatic ins_t blank();
      ins_t x;
      x.cmd = 4'h0; x.dest = 4'h0; x.st = 4'h0; x.rn = '0; x.rm = '0; x.rs = '0; x.pc = '0;
      x.imm = '0; x.shop = '0; x.simm = '0;
      x.i = 1'b0; x.s = 1'b0; x.mr = 1'b0; x.mw = 1'b0; x.wb = 1'b0; x.b = 1'b0;
      return x;
   endfunction

   function automatic ins_t alu_ins(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                                    input logic [11:0] shop, input logic [3:0] st);
      ins_t x = blank();
      x.cmd = cmd; x.rn = rn; x.rm = rm; x.shop = shop; x.st = st;
      x.s = 1'b1; x.wb = 1'b1; x.dest = cmd; x.pc = 32'h40;
      return x;
   endfunction

   // Reference: operand 2 built bit-by-bit, flags from 64-bit signed/unsigned arithmetic.
   function automatic logic [31:0] ref_val2();
      logic [31:0] v;
      int n;
      if (I) begin
         v = {24'h0, imm[7:0]};
         n = 2 * int'(imm[11:8]);
         for (int k = 0; k < n; k++) v = {v[0], v[31:1]};
      end else if (MEM_R_EN || MEM_W_EN) begin
         v = {20'h0, imm};
      end else begin
         v = Val_RM;
         n = int'(shift_operand[11:7]);
         for (int k = 0; k < n; k++)
            case (shift_operand[6:5])
               2'b00: v = {v[30:0], 1'b0};
               2'b01: v = {1'b0, v[31:1]};
               2'b10: v = {v[31], v[31:1]};
               default: v = {v[0], v[31:1]};
            endcase
      end
      return v;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      logic [31:0] v2, res;
      longint unsigned ua, ub, full;
      longint sa, sb, sres, off;
      logic c, v, arith;
      int borrow;
      v2 = ref_val2();
      ua = Val_RN; ub = v2;
      sa = $signed(Val_RN); sb = $signed(v2);
      c = status[1]; v = status[0]; arith = 1'b0; res = '0; sres = 0;
      borrow = status[1] ? 0 : 1;
      case (EXE_CMD)
         MOV: res = v2;
         MVN: res = ~v2;
         ADD: begin full = ua + ub; res = full[31:0]; c = full > 64'hFFFF_FFFF; sres = sa + sb; arith = 1; end
         ADC: begin full = ua + ub + longint'(status[1]); res = full[31:0]; c = full > 64'hFFFF_FFFF;
                    sres = sa + sb + longint'(status[1]); arith = 1; end
         SUB: begin res = Val_RN - v2; c = ua >= ub; sres = sa - sb; arith = 1; end
         SBC: begin res = Val_RN - v2 - 32'(borrow); c = ua >= ub + longint'(borrow);
                    sres = sa - sb - longint'(borrow); arith = 1; end
         AND: res = Val_RN & v2;
         ORR: res = Val_RN | v2;
         EOR: res = Val_RN ^ v2;
         default: res = '0;
      endcase
      if (arith) v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      e.st = {res[31], res == 0, c, v};
      if (EXE_CMD == MUL || EXE_CMD == MLA) begin
         if (MUL_EN) begin
            ua = Val_RM; ub = Val_RS; full = ua * ub;
            res = full[31:0] + ((EXE_CMD == MLA) ? Val_RN : 32'h0);
            e.st = {res[31], res == 0, status[1:0]};
         end else begin
            res = '0;
            e.st = status;
         end
      end
      off = longint'($signed(signed_immed_24));
      e.br = 32'(longint'(PC) + off * 4);
      e.alu = res; e.rm = Val_RM; e.dest = Dest;
      e.wb = WB_EN; e.mr = MEM_R_EN; e.mw = MEM_W_EN; e.b = B; e.s = S;
      return e;
   endfunction

   // Cycle model of the stage: valid flag, remaining multiply cycles, expected contents.
   bit   model_live = 1'b0;
   bit   m_valid = 1'b0;
   int   m_busy = 0;
   exp_t m_out, m_pend;

   always @(posedge clk) begin
      logic rdy, xfer;
      exp_t e;
      if (rst) begin
         model_live = 1'b1; m_valid = 1'b0; m_busy = 0;
      end else begin
         rdy  = (m_busy == 0) && (!m_valid || out_ready) && !flush;
         xfer = in_valid && rdy;
         if (flush) begin
            m_valid = 1'b0; m_busy = 0;
         end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_busy == 1) begin m_valid = 1'b1; m_out = m_pend; m_busy = 0; end
            else if (m_busy > 1) m_busy--;
            if (xfer) begin
               e = predict();
               if (MUL_EN && (EXE_CMD == MUL || EXE_CMD == MLA)) begin m_pend = e; m_busy = STEPS; end
               else begin m_out = e; m_valid = 1'b1; end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("in_ready", in_ready, !rst && m_busy == 0 && (!m_valid || out_ready) && !flush);
         chk("out_valid", out_valid, m_valid);
         chk("status_we", status_we, m_valid && m_out.s);
         if (m_valid) begin
            chk("ALU_result", ALU_result, m_out.alu);
            chk("status_out", status_out, m_out.st);
            chk("Val_RM_out", Val_RM_out, m_out.rm);
            chk("BranchAddr", BranchAddr, m_out.br);
            chk("ctrl_out", {Dest_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out},
                {m_out.dest, m_out.wb, m_out.mr, m_out.mw, m_out.b});
         end
      end
   end

   task automatic drive(input ins_t x);
      EXE_CMD = x.cmd; Dest = x.dest; status = x.st; Val_RN = x.rn; Val_RM = x.rm; Val_RS = x.rs;
      PC = x.pc; imm = x.imm; shift_operand = x.shop; signed_immed_24 = x.simm;
      I = x.i; S = x.s; MEM_R_EN = x.mr; MEM_W_EN = x.mw; WB_EN = x.wb; B = x.b;
   endtask

   // Called just after a rising edge; returns just after the edge that took the transfer.
   task automatic issue(input ins_t x, output int waited);
      drive(x);
      in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 40) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) chk("issue_timeout", 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   ins_t x, tab[9];
   logic [31:0] tab_exp[9];
   int w, cyc;

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(blank());
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outputs", {out_valid, status_we, ALU_result, BranchAddr, Dest_out, status_out}, '0);
      @(posedge clk); #1 rst = 1'b0;

      // ADD with signed overflow into the sign bit
      x = alu_ins(ADD, 32'h7FFF_FFFF, 0, 0, 4'b0000); x.i = 1'b1; x.imm = 12'h001;
      issue(x, w); @(negedge clk);
      chk("add_ovf_result", ALU_result, 32'h8000_0000);
      chk("add_ovf_flags", {status_out, status_we}, {4'b1001, 1'b1});
      @(posedge clk); #1;

      x = alu_ins(SUB, 5, 5, 12'h000, 4'b0000);
      issue(x, w); @(negedge clk);
      chk("sub_zero", {ALU_result, status_out}, {32'h0, 4'b0110});
      @(posedge clk); #1;

      x = alu_ins(MOV, 0, 0, 0, 4'b0000); x.i = 1'b1; x.imm = 12'h4FF; x.s = 1'b0;
      issue(x, w); @(negedge clk);
      chk("mov_rot_imm", ALU_result, 32'hFF00_0000);
      @(posedge clk); #1;

      x = alu_ins(MOV, 0, 32'h8000_0000, 12'h240, 4'b0000);
      issue(x, w); @(negedge clk);
      chk("mov_asr4", ALU_result, 32'hF800_0000);
      @(posedge clk); #1;

      x = alu_ins(MOV, 0, 32'h0000_00F1, 12'h260, 4'b0000);
      issue(x, w); @(negedge clk);
      chk("mov_ror4", ALU_result, 32'h1000_000F);
      @(posedge clk); #1;

      x = alu_ins(ADD, 32'h1000, 32'hDEAD_BEEF, 0, 4'b0000); x.mr = 1'b1; x.imm = 12'hFFF;
      issue(x, w); @(negedge clk);
      chk("ldr_offset", {ALU_result, Val_RM_out}, {32'h0000_1FFF, 32'hDEAD_BEEF});
      @(posedge clk); #1;

      // Directed ALU table
      tab[0] = alu_ins(ADC, 1, 1, 12'h000, 4'b0010);            tab_exp[0] = 32'h3;
      tab[1] = alu_ins(SBC, 5, 3, 12'h000, 4'b0000);            tab_exp[1] = 32'h1;
      tab[2] = alu_ins(SUB, 0, 1, 12'h000, 4'b0000);            tab_exp[2] = 32'hFFFF_FFFF;
      tab[3] = alu_ins(AND, 32'hF0F0, 32'hFF00, 12'h000, 4'b0011); tab_exp[3] = 32'hF000;
      tab[4] = alu_ins(ORR, 32'hF0F0, 32'hFF00, 12'h000, 4'b0000); tab_exp[4] = 32'hFFF0;
      tab[5] = alu_ins(EOR, 32'hF0F0, 32'hFF00, 12'h000, 4'b0000); tab_exp[5] = 32'h0FF0;
      tab[6] = alu_ins(MVN, 0, 0, 12'h000, 4'b0001);            tab_exp[6] = 32'hFFFF_FFFF;
      tab[7] = alu_ins(MOV, 0, 32'h80, 12'h1A0, 4'b0000);       tab_exp[7] = 32'h10;
      tab[8] = alu_ins(SUB, 32'h8000_0000, 1, 12'h000, 4'b0000); tab_exp[8] = 32'h7FFF_FFFF;
      for (int k = 0; k < 9; k++) begin
         issue(tab[k], w); @(negedge clk);
         chk($sformatf("table_%0d", k), ALU_result, tab_exp[k]);
         @(posedge clk); #1;
      end

      // MLA latency and result
      x = alu_ins(MLA, 1, 32'h1234, 0, 4'b0000); x.rs = 32'h10;
      issue(x, w);
      cyc = 1;
      @(negedge clk);
      while (!out_valid && cyc < 20) begin cyc++; @(negedge clk); end
      chk("mla_latency", cyc, EXP_MUL_LAT);
      chk("mla_result", ALU_result, EXP_MLA);
      @(posedge clk); #1;

      // Second instruction waits out the multiply
      x = alu_ins(MUL, 0, 32'h1111_1111, 0, 4'b0000); x.rs = 32'h0000_000F;
      issue(x, w);
      issue(alu_ins(ADD, 2, 3, 12'h000, 4'b0000), w);
      chk("mul_wait", w, EXP_MUL_WAIT);
      @(negedge clk);
      chk("after_mul_add", ALU_result, 32'h5);
      @(posedge clk); #1;

      // Back-pressure then back-to-back transfer
      x = alu_ins(ADD, 10, 0, 0, 4'b0000); x.i = 1'b1; x.imm = 12'h005;
      issue(x, w);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_hold", {out_valid, in_ready, ALU_result}, {1'b1, 1'b0, 32'd15});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      x = alu_ins(ADD, 20, 0, 0, 4'b0000); x.i = 1'b1; x.imm = 12'h007;
      issue(x, w);
      chk("b2b_wait", w, 0);
      @(negedge clk);
      chk("b2b_result", {out_valid, ALU_result}, {1'b1, 32'd27});
      @(posedge clk); #1;

      // Flush during a multiply
      x = alu_ins(MUL, 0, 3, 0, 4'b0000); x.rs = 7;
      issue(x, w);
      repeat (3) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_state", {in_ready, out_valid}, {1'b1, 1'b0});
      repeat (10) @(negedge clk);
      chk("flush_discard", out_valid, 0);
      @(posedge clk); #1;

      // Branch target
      x = blank(); x.b = 1'b1; x.pc = 32'h100; x.simm = 24'hFFFFFE; x.cmd = ADD;
      issue(x, w); @(negedge clk);
      chk("branch_addr", {BranchAddr, B_out}, {32'h0000_00F8, 1'b1});
      @(posedge clk); #1;

      // Reset in the middle of a multiply
      x = alu_ins(MLA, 9, 32'h55, 0, 4'b0000); x.rs = 32'h33; x.dest = 4'hA;
      issue(x, w);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mid_mul", {out_valid, status_we, in_ready, ALU_result, Val_RM_out, Dest_out, WB_EN_out},
          '0);
      @(posedge clk); #1 rst = 1'b0;
      issue(alu_ins(EOR, 32'hFFFF, 32'h00FF, 12'h000, 4'b0000), w);
      @(negedge clk);
      chk("post_rst_eor", ALU_result, 32'hFF00);
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
